// File: rtl/vga_layer_arbiter_pkg.sv
// vga_arb_pkg: shared types and width helpers for the VGA layer arbiter
package vga_arb_pkg;
    localparam int DEF_NUM_LAYERS = 4;
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;
    typedef enum logic {CFG_IDLE, CFG_PENDING} cfg_state_t;
    function automatic int idx_w(int n);
        return $clog2(n);
    endfunction
    function automatic int id_w(int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/vga_layer_arbiter_if.sv
// vga_layer_arbiter_if: configuration handshake carrying priority order and background colour
interface vga_layer_arbiter_if import vga_arb_pkg::*; #(
    parameter int NUM_LAYERS = DEF_NUM_LAYERS
) ();
    localparam int IDX_W = idx_w(NUM_LAYERS);
    logic                        valid;
    logic                        ready;
    logic [NUM_LAYERS*IDX_W-1:0] prio;
    rgb_t                        bg_rgb;
    logic                        error;
    modport master (output valid, prio, bg_rgb, input ready, error);
    modport slave (input valid, prio, bg_rgb, output ready, error);
endinterface

// File: rtl/vga_layer_arbiter_pick.sv
// layer_priority_pick: combinational winner selection, lowest priority slot with an active request wins
module layer_priority_pick import vga_arb_pkg::*; #(
    parameter int NUM_LAYERS = DEF_NUM_LAYERS,
    localparam int IDX_W = idx_w(NUM_LAYERS)
) (
    input  logic [NUM_LAYERS-1:0]       draw,
    input  logic [NUM_LAYERS*IDX_W-1:0] prio,
    output logic                        hit,
    output logic [IDX_W-1:0]            idx
);
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (draw[prio[k*IDX_W +: IDX_W]]) begin
                hit = 1'b1;
                idx = prio[k*IDX_W +: IDX_W];
            end
        end
    end
endmodule

// File: rtl/vga_layer_arbiter.sv
// vga_layer_arbiter: per-pixel layer arbitration with frame-synchronous config and collision latching
module vga_layer_arbiter import vga_arb_pkg::*; #(
    parameter int          NUM_LAYERS   = DEF_NUM_LAYERS,
    parameter logic [23:0] BG_RESET_RGB = 24'h000000,
    localparam int IDX_W = idx_w(NUM_LAYERS),
    localparam int ID_W  = id_w(NUM_LAYERS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_of_frame,
    input  logic [NUM_LAYERS-1:0]    layer_draw,
    input  logic [NUM_LAYERS*24-1:0] layer_rgb,
    vga_layer_arbiter_if.slave       cfg,
    output logic [7:0]               red,
    output logic [7:0]               green,
    output logic [7:0]               blue,
    output logic [ID_W-1:0]          draw_id,
    output logic [NUM_LAYERS-1:0]    collision,
    output logic                     collision_valid
);
    function automatic logic [NUM_LAYERS*IDX_W-1:0] ident();
        logic [NUM_LAYERS*IDX_W-1:0] r;
        for (int k = 0; k < NUM_LAYERS; k++) r[k*IDX_W +: IDX_W] = IDX_W'(k);
        return r;
    endfunction
    cfg_state_t                  state;
    logic [NUM_LAYERS*IDX_W-1:0] act_prio, pend_prio;
    rgb_t                        act_bg, pend_bg, pix;
    logic [NUM_LAYERS-1:0]       acc, ovl, seen;
    logic                        hit, perm_ok;
    logic [IDX_W-1:0]            win, cur;
    layer_priority_pick #(.NUM_LAYERS(NUM_LAYERS)) u_pick (
        .draw(layer_draw),
        .prio(act_prio),
        .hit (hit),
        .idx (win)
    );
    // every layer in an overlapping pixel collides with at least one other
    assign ovl = ($countones(layer_draw) > 1) ? layer_draw : '0;
    always_comb begin
        perm_ok = 1'b1;
        seen = '0;
        cur = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            cur = cfg.prio[k*IDX_W +: IDX_W];
            if (int'(cur) >= NUM_LAYERS || seen[cur]) perm_ok = 1'b0;
            else seen[cur] = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= CFG_IDLE;
            cfg.ready       <= 1'b1;
            cfg.error       <= 1'b0;
            act_prio        <= ident();
            act_bg          <= rgb_t'(BG_RESET_RGB);
            pend_prio       <= '0;
            pend_bg         <= '0;
            pix             <= '0;
            draw_id         <= ID_W'(NUM_LAYERS);
            acc             <= '0;
            collision       <= '0;
            collision_valid <= 1'b0;
        end else begin
            pix             <= hit ? rgb_t'(layer_rgb[24*win +: 24]) : act_bg;
            draw_id         <= hit ? ID_W'(win) : ID_W'(NUM_LAYERS);
            cfg.error       <= 1'b0;
            collision_valid <= start_of_frame;
            if (start_of_frame) begin
                collision <= acc;
                acc       <= '0;
            end else begin
                acc <= acc | ovl;
            end
            if (state == CFG_IDLE) begin
                if (cfg.valid && perm_ok) begin
                    pend_prio <= cfg.prio;
                    pend_bg   <= cfg.bg_rgb;
                    state     <= CFG_PENDING;
                    cfg.ready <= 1'b0;
                end else if (cfg.valid) begin
                    cfg.error <= 1'b1;
                end
            end else if (start_of_frame) begin
                act_prio  <= pend_prio;
                act_bg    <= pend_bg;
                state     <= CFG_IDLE;
                cfg.ready <= 1'b1;
            end
        end
    end
    assign red   = pix.r;
    assign green = pix.g;
    assign blue  = pix.b;
endmodule

// File: tb/tb_vga_layer_arbiter.sv
// tb_vga_layer_arbiter: directed stimulus with a queued scoreboard checked by an independent monitor
module tb_vga_layer_arbiter;
    import vga_arb_pkg::*;
    typedef struct {
        string       tag;
        logic [23:0] rgb;
        logic [2:0]  id;
        logic        rdy;
        logic        err;
        logic [3:0]  col;
        logic        cv;
    } exp_t;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_of_frame = 1'b0;
    logic [3:0]  layer_draw = '0;
    logic [95:0] layer_rgb = {24'h333333, 24'h00FF00, 24'hFF0000, 24'h111111};
    logic [7:0]  red, green, blue;
    logic [2:0]  draw_id;
    logic [3:0]  collision;
    logic        collision_valid;
    int          checks = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    vga_layer_arbiter_if #(.NUM_LAYERS(4)) cfg ();
    vga_layer_arbiter #(.NUM_LAYERS(4), .BG_RESET_RGB(24'h000000)) dut (
        .clk            (clk),
        .reset          (reset),
        .start_of_frame (start_of_frame),
        .layer_draw     (layer_draw),
        .layer_rgb      (layer_rgb),
        .cfg            (cfg),
        .red            (red),
        .green          (green),
        .blue           (blue),
        .draw_id        (draw_id),
        .collision      (collision),
        .collision_valid(collision_valid)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if ({red, green, blue} !== e.rgb || draw_id !== e.id || cfg.ready !== e.rdy ||
                cfg.error !== e.err || collision !== e.col || collision_valid !== e.cv) begin
                failures++;
                $display("FAIL %s: got rgb=%06h id=%0d rdy=%b err=%b col=%b cv=%b, want rgb=%06h id=%0d rdy=%b err=%b col=%b cv=%b",
                         e.tag, {red, green, blue}, draw_id, cfg.ready, cfg.error, collision, collision_valid,
                         e.rgb, e.id, e.rdy, e.err, e.col, e.cv);
            end
        end
    end
    task automatic step(input string tag, input logic r, input logic s, input logic [3:0] d,
                        input logic v, input logic [7:0] p, input logic [23:0] bg,
                        input logic [23:0] e_rgb, input int e_id, input logic e_rdy, input logic e_err,
                        input logic [3:0] e_col, input logic e_cv);
        exp_t e;
        @(negedge clk);
        reset = r;
        start_of_frame = s;
        layer_draw = d;
        cfg.valid = v;
        cfg.prio = p;
        cfg.bg_rgb = bg;
        e.tag = tag;
        e.rgb = e_rgb;
        e.id = 3'(e_id);
        e.rdy = e_rdy;
        e.err = e_err;
        e.col = e_col;
        e.cv = e_cv;
        exp_q.push_back(e);
    endtask
    initial begin
        cfg.valid = 1'b0;
        cfg.prio = 8'hE4;
        cfg.bg_rgb = '0;
        step("reset",        1, 0, 4'b0000, 0, 8'h00, 24'h0,      24'h000000, 4, 1, 0, 4'b0000, 0);
        step("empty",        0, 0, 4'b0000, 0, 8'h00, 24'h0,      24'h000000, 4, 1, 0, 4'b0000, 0);
        step("ident",        0, 0, 4'b0110, 0, 8'h00, 24'h0,      24'hFF0000, 1, 1, 0, 4'b0000, 0);
        step("cfg_accept",   0, 0, 4'b0110, 1, 8'h1B, 24'h0000FF, 24'hFF0000, 1, 0, 0, 4'b0000, 0);
        step("pend_win",     0, 0, 4'b0110, 0, 8'h00, 24'h0,      24'hFF0000, 1, 0, 0, 4'b0000, 0);
        step("pend_bg",      0, 0, 4'b0000, 0, 8'h00, 24'h0,      24'h000000, 4, 0, 0, 4'b0000, 0);
        step("sof_old_cfg",  0, 1, 4'b0110, 0, 8'h00, 24'h0,      24'hFF0000, 1, 1, 0, 4'b0110, 1);
        step("new_prio",     0, 0, 4'b0110, 0, 8'h00, 24'h0,      24'h00FF00, 2, 1, 0, 4'b0110, 0);
        step("new_bg",       0, 0, 4'b0000, 0, 8'h00, 24'h0,      24'h0000FF, 4, 1, 0, 4'b0110, 0);
        step("cfg_bad",      0, 0, 4'b0110, 1, 8'h90, 24'hABCDEF, 24'h00FF00, 2, 1, 1, 4'b0110, 0);
        step("err_end",      0, 0, 4'b0000, 0, 8'h00, 24'h0,      24'h0000FF, 4, 1, 0, 4'b0110, 0);
        step("sof_coll_a",   0, 1, 4'b0000, 0, 8'h00, 24'h0,      24'h0000FF, 4, 1, 0, 4'b0110, 1);
        step("ovl_02",       0, 0, 4'b0101, 0, 8'h00, 24'h0,      24'h00FF00, 2, 1, 0, 4'b0110, 0);
        step("alone_1",      0, 0, 4'b0010, 0, 8'h00, 24'h0,      24'hFF0000, 1, 1, 0, 4'b0110, 0);
        step("sof_coll_b",   0, 1, 4'b0000, 0, 8'h00, 24'h0,      24'h0000FF, 4, 1, 0, 4'b0101, 1);
        step("alone_0",      0, 0, 4'b0001, 0, 8'h00, 24'h0,      24'h111111, 0, 1, 0, 4'b0101, 0);
        step("alone_3",      0, 0, 4'b1000, 0, 8'h00, 24'h0,      24'h333333, 3, 1, 0, 4'b0101, 0);
        step("sof_no_ovl",   0, 1, 4'b0000, 0, 8'h00, 24'h0,      24'h0000FF, 4, 1, 0, 4'b0000, 1);
        step("cv_end",       0, 0, 4'b0000, 0, 8'h00, 24'h0,      24'h0000FF, 4, 1, 0, 4'b0000, 0);
        step("sof_accept",   0, 1, 4'b1000, 1, 8'hE4, 24'h123456, 24'h333333, 3, 0, 0, 4'b0000, 1);
        step("held_prio",    0, 0, 4'b1001, 0, 8'h00, 24'h0,      24'h333333, 3, 0, 0, 4'b0000, 0);
        step("held_bg",      0, 0, 4'b0000, 0, 8'h00, 24'h0,      24'h0000FF, 4, 0, 0, 4'b0000, 0);
        step("reset_pend",   1, 0, 4'b0110, 0, 8'h00, 24'h0,      24'h000000, 4, 1, 0, 4'b0000, 0);
        step("sof_after_rst",0, 1, 4'b0110, 0, 8'h00, 24'h0,      24'hFF0000, 1, 1, 0, 4'b0000, 1);
        step("rst_bg",       0, 0, 4'b0000, 0, 8'h00, 24'h0,      24'h000000, 4, 1, 0, 4'b0000, 0);
        step("rst_ident",    0, 0, 4'b1100, 0, 8'h00, 24'h0,      24'h00FF00, 2, 1, 0, 4'b0000, 0);
        @(negedge clk);
        layer_draw = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_layer_arbiter.md
Name: vga_layer_arbiter

Overview:
- Shares the single VGA pixel datapath between NUM_LAYERS drawing objects (background, player, enemies, score, …).
- Each cycle it selects the highest-priority layer asserting a draw request and registers that layer's RGB towards the VGA controller's Red/Green/Blue inputs.
- Priority order and background colour are configured through a valid/ready port; new configuration takes effect only at start of frame, so there is no mid-frame tearing.
- Latches per-layer overlap (collision) flags over each frame for the game logic.

Parameters:
- NUM_LAYERS, 4: number of requesting layers, range 2..8.
- BG_RESET_RGB, 24'h000000: background colour after reset, {R,G,B}.

Ports:
- clk  in  1  system pixel-domain clock.
- reset  in  1  synchronous, active-high reset.
- start_of_frame  in  1  one-cycle pulse from the VGA controller, asserted in vertical blanking.
- layer_draw  in  NUM_LAYERS  per-layer drawing request for the current pixel.
- layer_rgb  in  NUM_LAYERS*24  per-layer colour; layer i occupies bits [24i+23:24i], packed {R,G,B}.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration can be accepted.
- cfg_prio  in  NUM_LAYERS*IDX_W  slot k holds a layer index; slot 0 is highest priority.
- cfg_bg_rgb  in  24  background colour.
- cfg_error  out  1  one-cycle pulse: offered configuration rejected.
- red, green, blue  out  8 each  arbitrated pixel colour.
- draw_id  out  ID_W  winning layer index; NUM_LAYERS means background.
- collision  out  NUM_LAYERS  per-layer overlap flags for the previous frame.
- collision_valid  out  1  one-cycle pulse: collision updated.

Behaviour:
- Widths:
  - IDX_W = $clog2(NUM_LAYERS).
  - ID_W = $clog2(NUM_LAYERS+1).
- Reset values:
  - red/green/blue = 0.
  - draw_id = NUM_LAYERS.
  - cfg_ready = 1, cfg_error = 0.
  - collision = 0, collision_valid = 0.
  - Active priority = identity (slot k = layer k).
  - Active background = BG_RESET_RGB.
  - Pending config cleared; FSM in CFG_IDLE.
- Arbitration:
  - Winner = layer in the lowest slot k with layer_draw[prio[k]] = 1.
  - If no layer requests: background colour, draw_id = NUM_LAYERS.
  - Outputs are registered: inputs sampled in cycle n appear in cycle n+1. Fixed latency of 1 clock, no bubbles.
- Config FSM, two states:
  - CFG_IDLE:
    - cfg_ready = 1.
    - cfg_valid && permutation valid: copy cfg_prio and cfg_bg_rgb to the pending shadow; go to CFG_PENDING.
    - cfg_valid && invalid: cfg_error pulses for 1 cycle; stay in CFG_IDLE; the config is dropped.
    - A config is invalid if any index is >= NUM_LAYERS or any index is duplicated.
  - CFG_PENDING:
    - cfg_ready = 0; cfg_valid is ignored.
    - On start_of_frame: active <= pending; go to CFG_IDLE. cfg_ready = 1 from the next cycle.
- Simultaneous events:
  - Config accepted in the same cycle as start_of_frame is not applied at that frame; it waits for the next start_of_frame.
  - Arbitration in the start_of_frame cycle uses the old active config. The new config governs from the following cycle.
- Collision:
  - Accumulator acc[i] |= layer_draw[i] && (any other layer_draw[j], j≠i), for every cycle except start_of_frame cycles.
  - On start_of_frame: collision <= acc, acc <= 0, collision_valid = 1 on the next cycle only.
  - collision holds its value until the next start_of_frame.
- Reset mid-frame or mid-config: everything returns to reset values; a pending config is discarded.

Decomposition:
- Package vga_arb_pkg:
  - rgb_t, a packed struct {logic [7:0] r, g, b}.
  - cfg_state_t enum {CFG_IDLE, CFG_PENDING}.
  - Default NUM_LAYERS and the IDX_W/ID_W helper functions.
- Sub-module layer_priority_pick:
  - Purely combinational.
  - Inputs: draw vector and active priority array.
  - Outputs: winner valid, winner index.
  - Reused by the permutation check's sibling logic and by future sprite muxes.

Test Plan:
- Reset then layer_draw=4'b0000 -> next cycle RGB=000000, draw_id=4.
- Identity priority, layer_draw=4'b0110, layer1=FF0000, layer2=00FF00 -> next cycle RGB=FF0000, draw_id=1.
- Config prio={3,2,1,0} (slot0=3) and bg=0000FF accepted mid-frame:
  - Before the next start_of_frame, layer_draw=0110 still gives draw_id=1 and empty pixels give 000000.
  - After the start_of_frame cycle, draw_id=2 and empty pixels give 0000FF.
  - cfg_ready is 0 throughout the pending interval.
- Config prio={0,0,1,2} -> cfg_error pulses for 1 cycle, cfg_ready stays 1, outputs unchanged.
- Overlap stimulus:
  - Layers 0 and 2 both draw for 1 cycle; layer 1 draws alone.
  - At start_of_frame, next cycle: collision=4'b0101, collision_valid=1 for 1 cycle.
  - A following frame with no overlap yields collision=0.
- reset asserted while CFG_PENDING, then start_of_frame -> identity priority and BG_RESET_RGB remain active; collision=0.
